operand_fetch: RTL and testbench

Operand-fetch stage of the RISC machine datapath. It sits directly upstream of the ALU. It holds the 8×16-bit general register file and the A/B operand registers, and sequences two register-file reads through a single read port. It applies the B-operand shift and the A/B source selects, then presents `ain`/`bin` to the ALU under a valid/ready handshake. Writeback from the downstream result register enters through a dedicated write port.

---
 rtl/datapath_pkg.sv | 21 ++
 rtl/b_shifter.sv | 23 ++
 rtl/operand_fetch.sv | 113 +++++++++++
 tb/tb_operand_fetch.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath types and sizes for the operand-fetch, ALU and writeback stages.
package datapath_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    READ_A = 2'b01,
    READ_B = 2'b10,
    VALID  = 2'b11
  } of_state_t;

endpackage

// File: rtl/b_shifter.sv
// Single-bit B-operand shifter; the out-shifted bit is discarded.
module b_shifter
  import datapath_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] din,
  input  shift_op_t    op,
  output logic [W-1:0] dout
);

  always_comb begin
    dout = din;
    unique case (op)
      SH_NONE: dout = din;
      SH_LSL:  dout = {din[W-2:0], 1'b0};
      SH_LSR:  dout = {1'b0, din[W-1:1]};
      SH_ASR:  dout = {din[W-1], din[W-1:1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file, A/B operand registers and a 4-state
// sequencer that reads both operands through one read port before handing off.
module operand_fetch
  import datapath_pkg::*;
#(
  parameter int DATA_W = datapath_pkg::DATA_W,
  parameter int NREGS  = datapath_pkg::NREGS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     write,
  input  logic [$clog2(NREGS)-1:0] writenum,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [$clog2(NREGS)-1:0] rn,
  input  logic [$clog2(NREGS)-1:0] rm,
  input  logic [1:0]               shift,
  input  logic                     asel,
  input  logic                     bsel,
  input  logic [DATA_W-1:0]        sximm5,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        ain,
  output logic [DATA_W-1:0]        bin
);

  localparam int IDX_W = $clog2(NREGS);

  typedef struct packed {
    logic [IDX_W-1:0]  rn;
    logic [IDX_W-1:0]  rm;
    shift_op_t         shift;
    logic              asel;
    logic              bsel;
    logic [DATA_W-1:0] sximm5;
  } req_t;

  of_state_t                      state_q, state_d;
  req_t                           req_q;
  logic [NREGS-1:0][DATA_W-1:0]   rf;
  logic [DATA_W-1:0]              a_q, b_q, b_sh;
  logic                           ld_req, ld_a, ld_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    out_valid = 1'b0;
    ld_req    = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          ld_req  = 1'b1;
          state_d = READ_A;
        end
      end
      READ_A: begin
        ld_a    = 1'b1;
        state_d = READ_B;
      end
      READ_B: begin
        ld_b    = 1'b1;
        state_d = VALID;
      end
      VALID: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    req_q <= '0;
    else if (ld_req) req_q <= '{rn: rn, rm: rm, shift: shift_op_t'(shift),
                               asel: asel, bsel: bsel, sximm5: sximm5};
  end

  // Write port is always live; reads below see the pre-edge contents, so a
  // same-edge write to the read index is not forwarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rf <= '0;
    else if (write) rf[writenum] <= data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (ld_a) a_q <= rf[req_q.rn];
      if (ld_b) b_q <= rf[req_q.rm];
    end
  end

  b_shifter #(.W(DATA_W)) u_b_shifter (
    .din  (b_q),
    .op   (req_q.shift),
    .dout (b_sh)
  );

  assign ain = req_q.asel ? '0 : a_q;
  assign bin = req_q.bsel ? req_q.sximm5 : b_sh;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a scoreboard of expected ain/bin pairs.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        write = 1'b0;
  logic [2:0]  writenum = '0;
  logic [15:0] data_in = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  rn = '0, rm = '0;
  logic [1:0]  shift = '0;
  logic        asel = 1'b0, bsel = 1'b0;
  logic [15:0] sximm5 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] ain, bin;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  operand_fetch dut (
    .clk(clk), .reset_n(reset_n), .write(write), .writenum(writenum),
    .data_in(data_in), .req_valid(req_valid), .req_ready(req_ready),
    .rn(rn), .rm(rm), .shift(shift), .asel(asel), .bsel(bsel),
    .sximm5(sximm5), .out_valid(out_valid), .out_ready(out_ready),
    .ain(ain), .bin(bin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] idx, input logic [15:0] d);
    @(negedge clk);
    write = 1'b1; writenum = idx; data_in = d;
    @(posedge clk);
    #1 write = 1'b0;
  endtask

  // Drive one request for a single edge, then scramble the inputs so the
  // outputs can only be right if the request was latched.
  task automatic send(input logic [2:0] rn_i, input logic [2:0] rm_i,
                      input logic [1:0] sh_i, input logic as_i, input logic bs_i,
                      input logic [15:0] imm_i, input logic [15:0] ea,
                      input logic [15:0] eb);
    @(negedge clk);
    chk("send_ready", 32'(req_ready), 32'd1);
    rn = rn_i; rm = rm_i; shift = sh_i; asel = as_i; bsel = bs_i; sximm5 = imm_i;
    req_valid = 1'b1;
    sb.push_back('{a: ea, b: eb});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rn = ~rn_i; rm = ~rm_i; shift = ~sh_i; asel = ~as_i; bsel = ~bs_i; sximm5 = ~imm_i;
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (exp_lat > 0) chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic complete(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_ain"}, 32'(ain), 32'(e.a));
      chk({tag, "_bin"}, 32'(bin), 32'(e.b));
    end
    @(posedge clk);
    #1;
    chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_done_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ain", 32'(ain), 32'd0);
    chk("rst_bin", 32'(bin), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("rst_ready", 32'(req_ready), 32'd1);

    // basic read with latency check
    wr(3'd3, 16'h1234);
    wr(3'd5, 16'h00F0);
    send(3'd3, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h00F0);
    wait_out("basic", 3);
    complete("basic");

    // shift coverage
    wr(3'd2, 16'h8001);
    send(3'd2, 3'd2, 2'b01, 1'b0, 1'b0, 16'h0000, 16'h8001, 16'h0002);
    wait_out("lsl", 3);
    complete("lsl");
    send(3'd2, 3'd2, 2'b10, 1'b0, 1'b0, 16'h0000, 16'h8001, 16'h4000);
    wait_out("lsr", 3);
    complete("lsr");
    send(3'd2, 3'd2, 2'b11, 1'b0, 1'b0, 16'h0000, 16'h8001, 16'hC000);
    wait_out("asr", 3);
    complete("asr");

    // selects override register contents
    send(3'd3, 3'd5, 2'b01, 1'b1, 1'b1, 16'hFFFB, 16'h0000, 16'hFFFB);
    wait_out("sel", 3);
    complete("sel");

    // backpressure: write R3 and pulse req_valid while held in VALID
    out_ready = 1'b0;
    send(3'd3, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h00F0);
    wait_out("bp", 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
      chk("bp_hold_ain", 32'(ain), 32'h1234);
      chk("bp_hold_bin", 32'(bin), 32'h00F0);
      write = (i == 0); writenum = 3'd3; data_in = 16'hAAAA;
      req_valid = (i < 4); rn = 3'(i); rm = 3'(i); asel = 1'b1; bsel = 1'b1;
    end
    @(negedge clk);
    write = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    complete("bp");
    send(3'd3, 3'd0, 2'b00, 1'b0, 1'b0, 16'h0000, 16'hAAAA, 16'h0000);
    wait_out("bp_after", 3);
    complete("bp_after");

    // read/write collision on the READ_B edge
    send(3'd1, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h00F0);
    @(negedge clk);
    @(negedge clk);
    write = 1'b1; writenum = 3'd5; data_in = 16'h7777;
    @(posedge clk);
    #1 write = 1'b0;
    wait_out("col", 0);
    complete("col");
    send(3'd5, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h7777, 16'h7777);
    wait_out("col_new", 3);
    complete("col_new");

    // reset while in READ_B drops the transaction and clears the file
    send(3'd3, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0000, 16'hAAAA, 16'h7777);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ain", 32'(ain), 32'd0);
    chk("mid_rst_bin", 32'(bin), 32'd0);
    void'(sb.pop_back());
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("mid_rst_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_pulse", 32'(out_valid), 32'd0);
    end
    send(3'd3, 3'd5, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    wait_out("post_rst", 3);
    complete("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
